// File: rtl/lap_timer_pkg.sv
// lap_timer_pkg: shared constants and types for the stopwatch lap timer.
//   M1_* / M2_*   mode bus codes shared with the other dclock blocks
//   LAP_W         width of one lap FIFO entry {min,sec,tenths}
//   ts_e          timer state codes TS_IDLE / TS_RUN / TS_HOLD
//   tval_t        packed min:sec:tenths value; its layout is the lap entry layout
//   t_inc/t_dec   0.1 s increment (with wrap) / decrement of a tval_t
package lap_timer_pkg;

  localparam logic [1:0] M1_CLOCK = 2'd0;
  localparam logic [1:0] M1_ALARM = 2'd1;
  localparam logic [1:0] M1_TIMER = 2'd2;
  localparam logic [1:0] M1_SET   = 2'd3;

  localparam logic [1:0] M2_TIMER_G     = 2'd0;
  localparam logic [1:0] M2_TIMER_START = 2'd1;
  localparam logic [1:0] M2_TIMER_STOP  = 2'd2;
  localparam logic [1:0] M2_TIMER_NOP   = 2'd3;  // no timer command

  localparam int LAP_W = 16;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_HOLD = 2'd2
  } ts_e;

  typedef struct packed {
    logic [5:0] mins;
    logic [5:0] secs;
    logic [3:0] tenths;
  } tval_t;

  // +0.1 s; minutes wrap to 0 after wrap_min:59:9
  function automatic tval_t t_inc(tval_t t, logic [5:0] wrap_min);
    tval_t r;
    r = t;
    if (t.tenths == 4'd9) begin
      r.tenths = 4'd0;
      if (t.secs == 6'd59) begin
        r.secs = 6'd0;
        r.mins = (t.mins >= wrap_min) ? 6'd0 : t.mins + 6'd1;
      end else begin
        r.secs = t.secs + 6'd1;
      end
    end else begin
      r.tenths = t.tenths + 4'd1;
    end
    return r;
  endfunction

  // -0.1 s; saturates at 0:0:0
  function automatic tval_t t_dec(tval_t t);
    tval_t r;
    r = t;
    if (t != '0) begin
      if (t.tenths == 4'd0) begin
        r.tenths = 4'd9;
        if (t.secs == 6'd0) begin
          r.secs = 6'd59;
          r.mins = t.mins - 6'd1;
        end else begin
          r.secs = t.secs - 6'd1;
        end
      end else begin
        r.tenths = t.tenths - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lap_timer_if.sv
// lap_timer_if: mode bus, lap handshake and display outputs of the lap timer.
//   slave  : lap_timer side (takes mode1/mode2/lap_req/lap_rd, drives time + lap outputs)
//   master : controller / testbench side
// With TIMER_COUNTDOWN_EN defined the bus also carries dir, preset_min,
// preset_sec (to the timer) and expired (from the timer).
interface lap_timer_if;
  logic [1:0]  mode1;
  logic [1:0]  mode2;
  logic        lap_req;
  logic        lap_rd;
  logic [5:0]  min_sw;
  logic [5:0]  sec_sw;
  logic [3:0]  secc_sw;
  logic        lap_valid;
  logic [15:0] lap_data;
  logic [4:0]  lap_cnt;
  logic        lap_ovf;
`ifdef TIMER_COUNTDOWN_EN
  logic        dir;
  logic [5:0]  preset_min;
  logic [5:0]  preset_sec;
  logic        expired;

  modport slave (
    input  mode1, mode2, lap_req, lap_rd, dir, preset_min, preset_sec,
    output min_sw, sec_sw, secc_sw, lap_valid, lap_data, lap_cnt, lap_ovf, expired
  );
  modport master (
    output mode1, mode2, lap_req, lap_rd, dir, preset_min, preset_sec,
    input  min_sw, sec_sw, secc_sw, lap_valid, lap_data, lap_cnt, lap_ovf, expired
  );
`else
  modport slave (
    input  mode1, mode2, lap_req, lap_rd,
    output min_sw, sec_sw, secc_sw, lap_valid, lap_data, lap_cnt, lap_ovf
  );
  modport master (
    output mode1, mode2, lap_req, lap_rd,
    input  min_sw, sec_sw, secc_sw, lap_valid, lap_data, lap_cnt, lap_ovf
  );
`endif
endinterface

// File: rtl/lap_fifo.sv
// lap_fifo: DEPTH x W synchronous FIFO with synchronous active-high clear.
//   clk, clr        clock / clear (empties FIFO, zeroes storage)
//   push, din       write; taken when not full, or when full and a pop happens too
//   pop             read; ignored while empty
//   dout, valid     head entry (0 when empty) / not empty
//   full, cnt       full flag / number of stored entries 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module lap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             cnt_q;
  logic                    push_i, pop_i;

  assign valid  = cnt_q != '0;
  assign full   = cnt_q == (PW+1)'(DEPTH);
  assign pop_i  = pop && valid;
  // when full a simultaneous pop frees the slot being written
  assign push_i = push && (!full || pop_i);

  always_ff @(posedge clk) begin
    if (clr) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_i) rd_ptr <= rd_ptr + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout = valid ? mem[rd_ptr] : '0;
  assign cnt  = cnt_q;

endmodule

// File: rtl/lap_timer.sv
// lap_timer: stopwatch min:sec:tenths counter with tick prescaler and lap FIFO.
//   clk    system clock, rising edge
//   reset  synchronous reset, active high
//   bus    lap_timer_if.slave: mode1/mode2 commands, lap_req/lap_rd handshake,
//          min_sw/sec_sw/secc_sw time, lap_valid/lap_data/lap_cnt/lap_ovf
// Parameters: CLK_PER_TENTH (>=2) clocks per 0.1 s, LAP_DEPTH (power of two,
// 2..16) lap entries, MIN_WRAP last minute value before wrapping to 0:0:0.
// Optional feature TIMER_COUNTDOWN_EN: count-down from a preset with an
// expired pulse (bus.dir / preset_min / preset_sec / expired).
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int CLK_PER_TENTH = 10,
  parameter int LAP_DEPTH     = 4,
  parameter int MIN_WRAP      = 59
) (
  input logic          clk,
  input logic          reset,
  lap_timer_if.slave   bus
);
  localparam int             PSW   = $clog2(CLK_PER_TENTH);
  localparam logic [PSW-1:0] PS_TC = PSW'(CLK_PER_TENTH - 1);
  localparam logic [5:0]     WRAP  = 6'(MIN_WRAP);
  localparam int             CW    = $clog2(LAP_DEPTH) + 1;

  ts_e            state, state_nxt;
  tval_t          tval;
  logic [PSW-1:0] psc;
  logic           cmd_ok, clr, tick, lap_acc, pop_eff;
  logic           fifo_full, fifo_vld, ovf_q;
  logic [LAP_W-1:0] fifo_dout;
  logic [CW-1:0]  fifo_cnt;

  // mode2 is only meaningful while the timer owns the mode bus
  assign cmd_ok = bus.mode1 == M1_TIMER;

`ifdef TIMER_COUNTDOWN_EN
  logic       down_q, exp_q;
  logic [5:0] pre_min, pre_sec;
  assign pre_min = (bus.preset_min > WRAP)  ? WRAP  : bus.preset_min;
  assign pre_sec = (bus.preset_sec > 6'd59) ? 6'd59 : bus.preset_sec;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= TS_IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    if (cmd_ok) begin
      case (bus.mode2)
        M2_TIMER_G:     state_nxt = TS_IDLE;
        M2_TIMER_START: state_nxt = TS_RUN;
        M2_TIMER_STOP:  if (state == TS_RUN) state_nxt = TS_HOLD;
        default:        state_nxt = state;
      endcase
    end
`ifdef TIMER_COUNTDOWN_EN
    // count-down parks in HOLD at 0:0:0 (also when restarted already at zero)
    if (state == TS_RUN && down_q && !clr &&
        ((tick && tval == tval_t'(16'd1)) || tval == '0))
      state_nxt = TS_HOLD;
`endif
  end

  // FSM outputs
  always_comb begin
    clr     = cmd_ok && bus.mode2 == M2_TIMER_G;
    tick    = state == TS_RUN && psc == PS_TC;
    lap_acc = bus.lap_req && state != TS_IDLE && !clr;
  end

  // time counter and prescaler
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tval <= '0;
      psc  <= '0;
`ifdef TIMER_COUNTDOWN_EN
    end else if (state == TS_IDLE && bus.dir) begin
      tval <= '{mins: pre_min, secs: pre_sec, tenths: 4'd0};
`endif
    end else if (state == TS_RUN) begin
      psc <= tick ? '0 : psc + PSW'(1);
      if (tick) begin
`ifdef TIMER_COUNTDOWN_EN
        tval <= down_q ? t_dec(tval) : t_inc(tval, WRAP);
`else
        tval <= t_inc(tval, WRAP);
`endif
      end
    end
  end

`ifdef TIMER_COUNTDOWN_EN
  // direction is latched while idle so it cannot change mid-run
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      down_q <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      if (state == TS_IDLE) down_q <= bus.dir;
      exp_q <= tick && down_q && tval == tval_t'(16'd1);
    end
  end
  assign bus.expired = exp_q;
`endif

  // sticky overflow: a lap was accepted but had nowhere to go
  assign pop_eff = bus.lap_rd && fifo_vld;
  always_ff @(posedge clk) begin
    if (reset || clr)                           ovf_q <= 1'b0;
    else if (lap_acc && fifo_full && !pop_eff)  ovf_q <= 1'b1;
  end

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .W     (LAP_W)
  ) u_fifo (
    .clk   (clk),
    .clr   (reset || clr),
    .push  (lap_acc),
    .pop   (bus.lap_rd),
    .din   (tval),
    .dout  (fifo_dout),
    .valid (fifo_vld),
    .full  (fifo_full),
    .cnt   (fifo_cnt)
  );

  assign bus.min_sw    = tval.mins;
  assign bus.sec_sw    = tval.secs;
  assign bus.secc_sw   = tval.tenths;
  assign bus.lap_valid = fifo_vld;
  assign bus.lap_data  = fifo_dout;
  assign bus.lap_cnt   = 5'(fifo_cnt);
  assign bus.lap_ovf   = ovf_q;

endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed bench for lap_timer. Expected time is derived from
// the number of clocks spent running; lap captures go to a scoreboard queue
// when requested and are compared when popped.
module tb_lap_timer;
  import lap_timer_pkg::*;

  localparam int CPT   = 10;
  localparam int DEPTH = 4;
  localparam int WRAP  = 1;   // short minute range keeps the full wrap run small

  logic clk = 1'b0;
  logic reset = 1'b1;

  lap_timer_if bus ();

  lap_timer #(
    .CLK_PER_TENTH (CPT),
    .LAP_DEPTH     (DEPTH),
    .MIN_WRAP      (WRAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          run_edges = 0;
  bit          m_run = 1'b0;
  bit          m_idle = 1'b1;
  logic [15:0] lap_q[$];

  function automatic logic [15:0] exp_time(int re);
    int t;
    t = (re / CPT) % ((WRAP + 1) * 600);
    return {6'(t / 600), 6'((t / 10) % 60), 4'(t % 10)};
  endfunction

  function automatic logic [15:0] cur_time();
    return {bus.min_sw, bus.sec_sw, bus.secc_sw};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (m_run) run_edges++;
      #1;
    end
  endtask

  task automatic cmd(input logic [1:0] c);
    bus.mode1 = M1_TIMER;
    bus.mode2 = c;
    tick();
    bus.mode2 = M2_TIMER_NOP;
    case (c)
      M2_TIMER_G:     begin run_edges = 0; m_run = 0; m_idle = 1; lap_q.delete(); end
      M2_TIMER_START: begin m_run = 1; m_idle = 0; end
      M2_TIMER_STOP:  m_run = 0;
      default: ;
    endcase
  endtask

  // capture is the value registered before the request edge
  task automatic lap();
    bus.lap_req = 1'b1;
    if (!m_idle && lap_q.size() < DEPTH) lap_q.push_back(exp_time(run_edges));
    tick();
    bus.lap_req = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    check(tag, bus.lap_data, lap_q.pop_front());
    bus.lap_rd = 1'b1;
    tick();
    bus.lap_rd = 1'b0;
  endtask

  initial begin
    logic [15:0] cap;
    bus.mode1 = M1_CLOCK;
    bus.mode2 = M2_TIMER_NOP;
    bus.lap_req = 1'b0;
    bus.lap_rd = 1'b0;
`ifdef TIMER_COUNTDOWN_EN
    bus.dir = 1'b0;
    bus.preset_min = '0;
    bus.preset_sec = '0;
`endif
    tick(2);
    reset = 1'b0;
    check("rst_time", cur_time(), 0);
    check("rst_valid", bus.lap_valid, 0);
    check("rst_cnt", bus.lap_cnt, 0);
    check("rst_ovf", bus.lap_ovf, 0);
    check("rst_data", bus.lap_data, 0);

    // first tenth timing and full wrap
    cmd(M2_TIMER_G);
    cmd(M2_TIMER_START);
    tick(CPT - 1);
    check("first_tenth_early", bus.secc_sw, 0);
    tick(1);
    check("first_tenth", bus.secc_sw, 1);
    for (int i = 0; i < (WRAP + 1) * 600; i++) begin
      tick(CPT);
      check("run", cur_time(), exp_time(run_edges));
    end
    check("wrap", cur_time(), {6'd0, 6'd0, 4'd1});

    // hold and resume
    cmd(M2_TIMER_G);
    check("g_clear", cur_time(), 0);
    cmd(M2_TIMER_START);
    tick(1233);
    cmd(M2_TIMER_STOP);
    check("stop_val", cur_time(), {6'd0, 6'd12, 4'd3});
    tick(1000);
    check("hold_1000", cur_time(), {6'd0, 6'd12, 4'd3});
    cmd(M2_TIMER_START);
    tick(5);
    check("resume_early", cur_time(), {6'd0, 6'd12, 4'd3});
    tick(1);
    check("resume", cur_time(), {6'd0, 6'd12, 4'd4});
    cmd(M2_TIMER_G);
    check("g_after_resume", cur_time(), 0);

    // lap FIFO: fill, overflow, simultaneous push/pop, drain
    cmd(M2_TIMER_START);
    tick(9);
    lap();                       // lands on a tenth boundary
    for (int i = 0; i < 4; i++) begin
      tick(37);
      lap();
    end
    check("lap_full_cnt", bus.lap_cnt, DEPTH);
    check("lap_ovf_set", bus.lap_ovf, 1);
    check("lap_valid", bus.lap_valid, 1);
    check("lap_head_both", bus.lap_data, lap_q.pop_front());
    cap = exp_time(run_edges);
    bus.lap_req = 1'b1;
    bus.lap_rd = 1'b1;
    tick();
    bus.lap_req = 1'b0;
    bus.lap_rd = 1'b0;
    lap_q.push_back(cap);
    check("lap_both_cnt", bus.lap_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_chk("lap_pop");
    check("lap_empty_cnt", bus.lap_cnt, 0);
    check("lap_empty_valid", bus.lap_valid, 0);
    bus.lap_rd = 1'b1;
    tick();
    bus.lap_rd = 1'b0;
    check("rd_empty_cnt", bus.lap_cnt, 0);
    check("ovf_sticky", bus.lap_ovf, 1);
    cmd(M2_TIMER_G);
    check("ovf_g_clear", bus.lap_ovf, 0);

    // background counting, lap in HOLD and IDLE, STOP in IDLE
    cmd(M2_TIMER_START);
    tick(25);
    bus.mode1 = M1_CLOCK;
    bus.mode2 = M2_TIMER_G;
    tick(30);
    bus.mode1 = M1_TIMER;
    bus.mode2 = M2_TIMER_NOP;
    check("bg_run", cur_time(), exp_time(run_edges));
    cmd(M2_TIMER_STOP);
    lap();
    check("lap_hold_cnt", bus.lap_cnt, 1);
    pop_chk("lap_hold_pop");
    cmd(M2_TIMER_G);
    lap();
    check("lap_idle_cnt", bus.lap_cnt, 0);
    check("lap_idle_valid", bus.lap_valid, 0);
    cmd(M2_TIMER_STOP);
    tick(20);
    check("stop_idle", cur_time(), 0);

    // reset mid-run at 1:40:5 with a stored lap, overriding other inputs
    cmd(M2_TIMER_START);
    lap();
    tick(10050 - run_edges);
    check("pre_reset", cur_time(), {6'd1, 6'd40, 4'd5});
    check("pre_reset_cnt", bus.lap_cnt, 1);
    reset = 1'b1;
    bus.lap_req = 1'b1;
    bus.mode2 = M2_TIMER_START;
    m_run = 0;
    tick(2);
    reset = 1'b0;
    bus.lap_req = 1'b0;
    bus.mode2 = M2_TIMER_NOP;
    lap_q.delete();
    run_edges = 0;
    m_idle = 1;
    check("reset_time", cur_time(), 0);
    check("reset_cnt", bus.lap_cnt, 0);
    check("reset_valid", bus.lap_valid, 0);
    check("reset_data", bus.lap_data, 0);
    check("reset_ovf", bus.lap_ovf, 0);
    tick(15);
    check("reset_idle", cur_time(), 0);

`ifdef TIMER_COUNTDOWN_EN
    // count-down from 0:02
    cmd(M2_TIMER_G);
    bus.dir = 1'b1;
    bus.preset_min = 6'd50;
    bus.preset_sec = 6'd63;
    tick();
    check("preset_sat", cur_time(), {6'(WRAP), 6'd59, 4'd0});
    bus.preset_min = 6'd0;
    bus.preset_sec = 6'd2;
    tick();
    check("preset", cur_time(), {6'd0, 6'd2, 4'd0});
    cmd(M2_TIMER_START);
    tick(199);
    check("cd_199", cur_time(), {6'd0, 6'd0, 4'd1});
    check("cd_199_exp", bus.expired, 0);
    tick(1);
    check("cd_zero", cur_time(), 0);
    check("cd_expired", bus.expired, 1);
    tick(1);
    check("cd_exp_pulse", bus.expired, 0);
    tick(30);
    check("cd_hold", cur_time(), 0);
    cmd(M2_TIMER_START);
    for (int i = 0; i < 20; i++) check("cd_no_repulse", bus.expired, 0), tick();
    check("cd_restart_zero", cur_time(), 0);
    bus.dir = 1'b0;
    cmd(M2_TIMER_G);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
